// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory controller for a RISC-V style load/store
// unit. Requests are accepted with a valid/ready handshake, held for
// WAIT_CYCLES wait states, then answered with a one-cycle response strobe.
// Loads are sign/zero extended; stores write only the addressed byte lanes.
//
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W
// accesses. Without it, misaligned accesses are silently forced aligned.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_* are don't-care otherwise. rsp_valid is a
// single-cycle strobe, and rsp_rdata/rsp_fault hold until the next response.
module dmem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAST_CNT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [31:0] mem [DEPTH];

    // Access operands: the latched request while waiting, otherwise the live
    // request (only used when WAIT_CYCLES is 0 and RESP is entered directly).
    logic        acc_we;
    logic [2:0]  acc_f3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        bad_f3;
    logic        range_err;
    logic        misal;
    logic        acc_fault;
    logic [31:0] eff_addr;
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [3:0]  wmask;
    logic [31:0] wword;
    logic        accept;
    logic        do_access;

    // Decode the access: fault detection, alignment, lane selection, extension
    always_comb begin
        acc_we    = (state_q == WAIT) ? we_q    : req_we;
        acc_f3    = (state_q == WAIT) ? f3_q    : req_funct3;
        acc_addr  = (state_q == WAIT) ? addr_q  : req_addr;
        acc_wdata = (state_q == WAIT) ? wdata_q : req_wdata;

        bad_f3 = (acc_f3 == 3'd3) || (acc_f3 == 3'd6) || (acc_f3 == 3'd7) ||
                 (acc_we && ((acc_f3 == 3'd4) || (acc_f3 == 3'd5)));
        range_err = |(acc_addr >> (AW + 2));
        misal = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));

        eff_addr = acc_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_fault = bad_f3 || range_err || misal;
`else
        acc_fault = bad_f3 || range_err;
        if (misal) begin
            if (acc_f3[1:0] == 2'b01) eff_addr[0]   = 1'b0;
            else                      eff_addr[1:0] = 2'b00;
        end
`endif

        idx     = eff_addr[AW+1:2];
        word    = mem[idx];
        ld_byte = word[8*eff_addr[1:0] +: 8];
        ld_half = word[16*eff_addr[1] +: 16];

        case (acc_f3)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = word;
        endcase

        case (acc_f3[1:0])
            2'b00: begin
                wmask = 4'b0001 << eff_addr[1:0];
                wword = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                wmask = eff_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{acc_wdata[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wword = acc_wdata;
            end
        endcase
    end

    // Next-state, request latching and response capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        do_access = 1'b0;
        req_ready = (state_q == IDLE) || (state_q == RESP);
        accept    = req_valid && req_ready;

        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'd0;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d   = RESP;
                    cnt_d     = 4'd0;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_access) begin
            fault_d = acc_fault;
            rdata_d = (acc_fault || acc_we) ? 32'd0 : ld_data;
        end
    end

    // State and response registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Byte-lane memory write on the edge entering RESP; contents are not reset
    always_ff @(posedge clk) begin
        if (rst_n && do_access && acc_we && !acc_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: directed scenarios plus randomized traffic checked
// against a byte-addressed reference model of the memory.
module tb_dmem_ctrl;
    localparam int TB_DEPTH = 1024;
    localparam int TB_WAIT  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem_b [TB_DEPTH*4];

    dmem_ctrl #(.DEPTH(TB_DEPTH), .WAIT_CYCLES(TB_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: byte memory, RISC-V width rules, fault rules
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic flt);
        int size;
        logic [31:0] v;
        size = 1 << f3[1:0];
        rd = 32'd0;
        flt = 1'b0;
        if (f3 == 3 || f3 >= 6 || (we && f3 >= 4) || a >= 32'(TB_DEPTH * 4)) flt = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        else if (a % size != 0) flt = 1'b1;
`endif
        if (flt) return;
        a = a - (a % size);
        if (we) begin
            for (int i = 0; i < size; i++) mem_b[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
        end
    endfunction

    // Driver: issue one request, wait for its response; lat counts edges from accept
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                          output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 40) begin @(negedge clk); guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom); req_we = 1'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata;
        flt = rsp_fault;
    endtask

    // Driver plus model update in one step
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic flt, output int lat,
                       output logic [31:0] erd, output logic eflt);
        do_req(we, f3, a, wd, rd, flt, lat);
        model(we, f3, a, wd, erd, eflt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata); else n_pass++;
        n_checks++; if (rsp_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", rsp_fault); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Bring the region used by the bench to a known zero state
    task automatic test_init();
        logic [31:0] rd, erd; logic flt, eflt; int lat; int bad;
        bad = 0;
        for (int w = 0; w < 256; w++) begin
            txn(1'b1, 3'd2, 32'(w * 4), 32'd0, rd, flt, lat, erd, eflt);
            if (flt !== 1'b0 || lat != TB_WAIT + 1) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL init_stores: got %0d bad responses want 0", bad); else n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] rd, erd, v0; logic flt, eflt; int lat;
        txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, rd, flt, lat, erd, eflt);
        n_checks++; if (lat != TB_WAIT + 1) $display("FAIL sw_latency: got %0d want %0d", lat, TB_WAIT + 1); else n_pass++;
        n_checks++; if (flt !== 1'b0 || rd !== 32'd0) $display("FAIL sw_rsp: got %b/%h want 0/0", flt, rd); else n_pass++;
        txn(1'b0, 3'd2, 32'h100, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (lat != TB_WAIT + 1) $display("FAIL lw_latency: got %0d want %0d", lat, TB_WAIT + 1); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF || flt !== 1'b0) $display("FAIL lw_word: got %h/%b want deadbeef/0", rd, flt); else n_pass++;

        txn(1'b1, 3'd2, 32'h100, 32'd0, rd, flt, lat, erd, eflt);
        txn(1'b1, 3'd0, 32'h101, 32'h80, rd, flt, lat, erd, eflt);
        txn(1'b0, 3'd0, 32'h101, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (rd !== 32'hFFFFFF80) $display("FAIL lb_sext: got %h want ffffff80", rd); else n_pass++;
        txn(1'b0, 3'd4, 32'h101, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (rd !== 32'h00000080) $display("FAIL lbu_zext: got %h want 00000080", rd); else n_pass++;
        txn(1'b0, 3'd2, 32'h100, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (rd !== 32'h00008000) $display("FAIL sb_lane: got %h want 00008000", rd); else n_pass++;

        // Store data is right-aligned: SH writes the low half 0xABCD into lanes 2..3
        txn(1'b1, 3'd1, 32'h202, 32'h1234ABCD, rd, flt, lat, erd, eflt);
        txn(1'b0, 3'd1, 32'h202, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (rd !== erd || rd !== 32'hFFFFABCD) $display("FAIL lh_upper: got %h want %h", rd, erd); else n_pass++;
        txn(1'b0, 3'd5, 32'h200, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (rd !== 32'h00000000) $display("FAIL lhu_lower: got %h want 00000000", rd); else n_pass++;

        v0 = $urandom | 32'h1;
        txn(1'b1, 3'd2, 32'h0, v0, rd, flt, lat, erd, eflt);
        txn(1'b1, 3'd2, 32'h1000, ~v0, rd, flt, lat, erd, eflt);
        n_checks++; if (flt !== 1'b1 || rd !== 32'd0) $display("FAIL sw_range_fault: got %b/%h want 1/0", flt, rd); else n_pass++;
        txn(1'b0, 3'd2, 32'h0, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (rd !== v0 || flt !== 1'b0) $display("FAIL range_no_write: got %h want %h", rd, v0); else n_pass++;
        txn(1'b0, 3'd3, 32'h0, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (flt !== 1'b1 || rd !== 32'd0) $display("FAIL f3_3_fault: got %b/%h want 1/0", flt, rd); else n_pass++;

        txn(1'b1, 3'd2, 32'h100, 32'h87654321, rd, flt, lat, erd, eflt);
        txn(1'b0, 3'd1, 32'h103, 32'd0, rd, flt, lat, erd, eflt);
`ifdef DMEM_MISALIGN_TRAP_EN
        n_checks++; if (flt !== 1'b1 || rd !== 32'd0) $display("FAIL lh_misalign: got %b/%h want 1/0", flt, rd); else n_pass++;
`else
        n_checks++; if (flt !== 1'b0 || rd !== 32'hFFFF8765) $display("FAIL lh_misalign: got %b/%h want 0/ffff8765", flt, rd); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a; logic flt, eflt, we; logic [2:0] f3; int lat; int bad;
        bad = 0;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 1023));
            txn(we, f3, a, $urandom, rd, flt, lat, erd, eflt);
            if (rd !== erd || flt !== eflt || lat != TB_WAIT + 1) begin
                bad++;
                if (bad <= 5) $display("FAIL random_txn: we=%b f3=%0d a=%h got %h/%b/%0d want %h/%b/%0d",
                                       we, f3, a, rd, flt, lat, erd, eflt, TB_WAIT + 1);
            end
        end
        n_checks++; if (bad != 0) $display("FAIL random_total: got %0d bad want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd, erd, v; logic flt, eflt; int lat; int seen;
        v = $urandom | 32'h1;
        txn(1'b1, 3'd2, 32'h40, v, rd, flt, lat, erd, eflt);
        txn(1'b0, 3'd2, 32'h40, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (rd !== v) $display("FAIL pre_reset_lw: got %h want %h", rd, v); else n_pass++;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = ~v;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (rsp_valid !== 1'b0) seen++; end
        n_checks++; if (seen != 0) $display("FAIL reset_in_wait_valid: got %0d strobes want 0", seen); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'd0 || rsp_fault !== 1'b0) $display("FAIL reset_in_wait_rsp: got %h/%b want 0/0", rsp_rdata, rsp_fault); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        txn(1'b0, 3'd2, 32'h40, 32'd0, rd, flt, lat, erd, eflt);
        n_checks++; if (rd !== v || rd !== erd) $display("FAIL reset_no_write: got %h want %h", rd, v); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, v, erd; logic eflt; int t, gap;
        a = 32'($urandom_range(0, 255) * 4);
        v = $urandom;
        @(negedge clk);
        t = 0;
        while (!req_ready && t < 40) begin @(negedge clk); t++; end
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = a; req_wdata = v;
        @(posedge clk); #1;
        req_we = 1'b0; req_wdata = 32'd0;
        model(1'b1, 3'd2, a, v, erd, eflt);
        model(1'b0, 3'd2, a, 32'd0, erd, eflt);
        t = 0;
        while (!rsp_valid && t < 40) begin @(posedge clk); #1; t++; end
        n_checks++; if (rsp_valid !== 1'b1 || rsp_fault !== 1'b0) $display("FAIL b2b_first: got %b/%b want 1/0", rsp_valid, rsp_fault); else n_pass++;
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
            if (gap == 1) req_valid = 1'b0;
        end while (!rsp_valid && gap < 40);
        n_checks++; if (gap != TB_WAIT + 1) $display("FAIL b2b_gap: got %0d want %0d", gap, TB_WAIT + 1); else n_pass++;
        n_checks++; if (rsp_rdata !== erd || rsp_fault !== 1'b0) $display("FAIL b2b_data: got %h want %h", rsp_rdata, erd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_directed();
        test_random();
        test_reset_wait();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
